// File: rtl/ttl_74298_mux_sched.sv
// ttl_74298_mux_sched: two-source arbiter driving WS/Cen of a 74LS298 mux-latch bank
// Ports: clk, VIDEO_RSTn (async active-low), ce (phase tick), req_a/req_b (held until ack),
//        WS (0=A,1=B), Cen (idle high, falling edge stores), ack_a/ack_b (one-clk), busy.
// Build option: MUX_SCHED_FIXED_PRIO_EN selects fixed priority (A wins); default is round-robin.
module ttl_74298_mux_sched #(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 1,
    parameter int RECOVER_CYC = 1
) (
    input  logic clk,
    input  logic VIDEO_RSTn,
    input  logic ce,
    input  logic req_a,
    input  logic req_b,
    output logic WS,
    output logic Cen,
    output logic ack_a,
    output logic ack_b,
    output logic busy
);
    if (SETUP_CYC < 1 || SETUP_CYC > 255 || STROBE_CYC < 1 || STROBE_CYC > 255 ||
        RECOVER_CYC < 1 || RECOVER_CYC > 255) begin : g_bad_param
        $error("ttl_74298_mux_sched: phase lengths must be 1..255");
    end

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, RECOVER, DONE} state_t;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       ws_n, cen_n, ack_a_n, ack_b_n, win_b;
    logic       start;

    assign start = state == IDLE && (req_a || req_b);

`ifdef MUX_SCHED_FIXED_PRIO_EN
    assign win_b = req_b && !req_a;
`else
    logic last_grant;
    // both requesting: B wins only if A was served last
    assign win_b = req_b && (!req_a || !last_grant);
    always_ff @(posedge clk or negedge VIDEO_RSTn)
        if (!VIDEO_RSTn) last_grant <= 1'b1;
        else if (start) last_grant <= win_b;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ws_n    = WS;
        cen_n   = Cen;
        ack_a_n = 1'b0;
        ack_b_n = 1'b0;
        case (state)
            IDLE:
                if (start) begin
                    state_n = SETUP;
                    ws_n    = win_b;
                    cnt_n   = 8'(SETUP_CYC - 1);
                end
            SETUP:
                if (ce) begin
                    if (cnt == 8'd0) begin
                        state_n = STROBE;
                        cen_n   = 1'b0;
                        cnt_n   = 8'(STROBE_CYC - 1);
                    end else cnt_n = cnt - 8'd1;
                end
            STROBE:
                if (ce) begin
                    if (cnt == 8'd0) begin
                        state_n = RECOVER;
                        cen_n   = 1'b1;
                        cnt_n   = 8'(RECOVER_CYC - 1);
                    end else cnt_n = cnt - 8'd1;
                end
            RECOVER:
                if (ce) begin
                    if (cnt == 8'd0) begin
                        state_n = DONE;
                        ack_a_n = !WS;
                        ack_b_n = WS;
                    end else cnt_n = cnt - 8'd1;
                end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge VIDEO_RSTn)
        if (!VIDEO_RSTn) begin
            state <= IDLE;
            cnt   <= 8'd0;
            WS    <= 1'b0;
            Cen   <= 1'b1;
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            WS    <= ws_n;
            Cen   <= cen_n;
            ack_a <= ack_a_n;
            ack_b <= ack_b_n;
            busy  <= state_n != IDLE;
        end
endmodule
